alu_65ce02_wide: RTL and testbench

ALU_65CE02_WIDE -- requirements
Module: alu_65ce02_wide

---
 rtl/alu_65ce02_pkg.sv | 47 ++++
 rtl/alu_65ce02_byte_slice.sv | 62 ++++++
 rtl/alu_65ce02_wide.sv | 192 +++++++++++++++++++
 tb/tb_alu_65ce02_wide.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_65ce02_pkg.sv
// Shared definitions for the byte-serial 65CE02-style ALU: op codes, FSM
// state encoding and small arithmetic helpers.
package alu_65ce02_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_PASS = 4'b0101;
    localparam logic [3:0] OP_ASL  = 4'b0110;
    localparam logic [3:0] OP_ROL  = 4'b0111;
    localparam logic [3:0] OP_LSR  = 4'b1000;
    localparam logic [3:0] OP_ROR  = 4'b1001;
    localparam logic [3:0] OP_INC  = 4'b1010;
    localparam logic [3:0] OP_DEC  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Decimal nibble add: returns {carry, adjusted nibble}.
    function automatic logic [4:0] bcd_nibble_add(input logic [3:0] a,
                                                  input logic [3:0] b,
                                                  input logic       c);
        logic [5:0] raw;
        logic [5:0] adj;
        raw = {2'b00, a} + {2'b00, b} + {5'b00000, c};
        if (raw > 6'd9) begin
            adj = raw + 6'd6;
        end else begin
            adj = raw;
        end
        return {(raw > 6'd9), adj[3:0]};
    endfunction

    // Chain bit loaded before the first byte; INC/DEC get their +1/-1 via the B byte.
    function automatic logic init_chain(input logic [3:0] op, input logic ci);
        case (op)
            OP_ASL, OP_LSR, OP_INC, OP_DEC: return 1'b0;
            default:                        return ci;
        endcase
    endfunction

endpackage

// File: rtl/alu_65ce02_byte_slice.sv
// Combinational one-byte ALU slice; the top feeds it one byte per RUN cycle
// and registers the chain bit between bytes.
module alu_65ce02_byte_slice
    import alu_65ce02_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       chain_in,
    input  logic       bcd,
    output logic [7:0] y,
    output logic       chain_out,
    output logic       half_co
);

    logic [7:0] bop_s;
    logic [8:0] sum_s;
    logic [4:0] lo_s;
    logic [4:0] hi_s;

    // Byte result and outgoing chain bit for the selected operation
    always_comb begin
        bop_s = (op == OP_SUB) ? ~b : b;
        sum_s = {1'b0, a} + {1'b0, bop_s} + {8'h00, chain_in};
        lo_s  = bcd_nibble_add(a[3:0], b[3:0], chain_in);
        hi_s  = bcd_nibble_add(a[7:4], b[7:4], lo_s[4]);
        y         = a;
        chain_out = chain_in;
        half_co   = 1'b0;
        case (op)
            OP_ADD: begin
                if (bcd) begin
                    y         = {hi_s[3:0], lo_s[3:0]};
                    chain_out = hi_s[4];
                    half_co   = lo_s[4];
                end else begin
                    y         = sum_s[7:0];
                    chain_out = sum_s[8];
                    half_co   = a[4] ^ bop_s[4] ^ sum_s[4];
                end
            end
            OP_SUB, OP_INC, OP_DEC: begin
                y         = sum_s[7:0];
                chain_out = sum_s[8];
                half_co   = a[4] ^ bop_s[4] ^ sum_s[4];
            end
            OP_OR:  y = a | b;
            OP_AND: y = a & b;
            OP_XOR: y = a ^ b;
            OP_ASL, OP_ROL: begin
                y         = {a[6:0], chain_in};
                chain_out = a[7];
            end
            OP_LSR, OP_ROR: begin
                y         = {chain_in, a[7:1]};
                chain_out = a[0];
            end
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu_65ce02_wide.sv
// Byte-serial WIDTH-bit 65CE02-style ALU: captures operands on start, runs
// one byte per RDY-high cycle, then publishes result and flags with done.
module alu_65ce02_wide
    import alu_65ce02_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RDY,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             BCD,
    input  logic             CI,
    input  logic [WIDTH-1:0] AI,
    input  logic [WIDTH-1:0] BI,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] OUT,
    output logic             CO,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int BYTES = WIDTH / 8;
    localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES - 1);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             bcd_q, bcd_d, ci_q, ci_d, chain_q, chain_d, zacc_q, zacc_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, shadow_q, shadow_d, out_q, out_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             co_q, co_d, v_q, v_d, z_q, z_d, n_q, n_d, busy_q, busy_d, done_q, done_d;

    logic             rev_s, bop_msb_s, sl_co_s, unused_half_co_s;
    logic [IDXW-1:0]  pos_s;
    logic [7:0]       sl_a_s, sl_b_s, sl_y_s;
    logic [WIDTH-1:0] res_full_s;

    alu_65ce02_byte_slice u_slice (
        .op        (op_q),
        .a         (sl_a_s),
        .b         (sl_b_s),
        .chain_in  (chain_q),
        .bcd       (bcd_q),
        .y         (sl_y_s),
        .chain_out (sl_co_s),
        .half_co   (unused_half_co_s)
    );

    // Byte position and slice operands; LSR/ROR walk from the top byte down
    always_comb begin
        rev_s = (op_q == OP_LSR) || (op_q == OP_ROR);
        if (rev_s) begin
            pos_s = LAST_IDX - idx_q;
        end else begin
            pos_s = idx_q;
        end
        sl_a_s = a_q[{pos_s, 3'b000} +: 8];
        case (op_q)
            OP_INC:  sl_b_s = (idx_q == {IDXW{1'b0}}) ? 8'h01 : 8'h00;
            OP_DEC:  sl_b_s = 8'hFF;
            default: sl_b_s = b_q[{pos_s, 3'b000} +: 8];
        endcase
        res_full_s = shadow_q;
        res_full_s[{pos_s, 3'b000} +: 8] = sl_y_s;
        bop_msb_s = (op_q == OP_SUB) ? ~b_q[WIDTH-1] : b_q[WIDTH-1];
    end

    // FSM next state, operand capture, per-byte accumulation and final flags
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        bcd_d    = bcd_q;
        ci_d     = ci_q;
        a_d      = a_q;
        b_d      = b_q;
        chain_d  = chain_q;
        zacc_d   = zacc_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        out_d    = out_q;
        co_d     = co_q;
        v_d      = v_q;
        z_d      = z_q;
        n_d      = n_q;
        busy_d   = busy_q;
        done_d   = done_q;
        if (RDY) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_d     = op;
                        bcd_d    = BCD;
                        ci_d     = CI;
                        a_d      = AI;
                        b_d      = BI;
                        chain_d  = init_chain(op, CI);
                        zacc_d   = 1'b1;
                        shadow_d = {WIDTH{1'b0}};
                        idx_d    = {IDXW{1'b0}};
                        busy_d   = 1'b1;
                        state_d  = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    shadow_d = res_full_s;
                    chain_d  = sl_co_s;
                    zacc_d   = zacc_q & (sl_y_s == 8'h00);
                    if (idx_q == LAST_IDX) begin
                        out_d   = res_full_s;
                        co_d    = sl_co_s;
                        z_d     = zacc_q & (sl_y_s == 8'h00);
                        n_d     = res_full_s[WIDTH-1];
                        v_d     = ((op_q == OP_ADD) || (op_q == OP_SUB)) ?
                                  (a_q[WIDTH-1] ^ bop_msb_s ^ sl_co_s ^ res_full_s[WIDTH-1]) : 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State register with synchronous reset overriding the RDY stall
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 4'h0;
            bcd_q    <= 1'b0;
            ci_q     <= 1'b0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            chain_q  <= 1'b0;
            zacc_q   <= 1'b1;
            shadow_q <= {WIDTH{1'b0}};
            idx_q    <= {IDXW{1'b0}};
            out_q    <= {WIDTH{1'b0}};
            co_q     <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b1;
            n_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            bcd_q    <= bcd_d;
            ci_q     <= ci_d;
            a_q      <= a_d;
            b_q      <= b_d;
            chain_q  <= chain_d;
            zacc_q   <= zacc_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            out_q    <= out_d;
            co_q     <= co_d;
            v_q      <= v_d;
            z_q      <= z_d;
            n_q      <= n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign OUT  = out_q;
    assign CO   = co_q;
    assign V    = v_q;
    assign Z    = z_q;
    assign N    = n_q;

endmodule

// File: tb/tb_alu_65ce02_wide.sv
// Directed self-checking bench for alu_65ce02_wide at WIDTH=16.
module tb_alu_65ce02_wide;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset, RDY, start, BCD, CI;
    logic [3:0]       op;
    logic [WIDTH-1:0] AI, BI, OUT;
    logic             busy, done, CO, V, Z, N;

    int   checks   = 0;
    int   failures = 0;
    int   lat;
    int   seen;
    logic busy1;

    always #5 clk = ~clk;

    alu_65ce02_wide #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .RDY   (RDY),
        .start (start),
        .op    (op),
        .BCD   (BCD),
        .CI    (CI),
        .AI    (AI),
        .BI    (BI),
        .busy  (busy),
        .done  (done),
        .OUT   (OUT),
        .CO    (CO),
        .V     (V),
        .Z     (Z),
        .N     (N)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op; optional RDY-low cycles right after acceptance, optional
    // junk start (different operands) held high while the DUT is busy.
    task automatic run_op(input logic [3:0] o, input logic b, input logic c,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] bb,
                          input int rdy_low, input logic junk);
        @(posedge clk); #1;
        op = o; BCD = b; CI = c; AI = a; BI = bb; start = 1'b1;
        @(posedge clk); #1;
        lat   = 1;
        busy1 = busy;
        if (junk) begin
            op = 4'h1; AI = ~a; BI = ~bb; CI = ~c;
        end else begin
            start = 1'b0;
        end
        if (rdy_low > 0) begin
            RDY = 1'b0;
            repeat (rdy_low) begin
                @(posedge clk); #1;
                lat++;
            end
            RDY = 1'b1;
        end
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; RDY = 1'b0; start = 1'b0; op = 4'h0; BCD = 1'b0; CI = 1'b0;
        AI = '0; BI = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; RDY = 1'b1;
        check("rst_out",  OUT, 32'h0);
        check("rst_z",    Z, 32'h1);
        check("rst_flags", {CO, V, N}, 32'h0);
        check("rst_busy_done", {busy, done}, 32'h0);

        run_op(4'h0, 1'b0, 1'b0, 16'h12FF, 16'h0001, 0, 1'b0);
        check("add_lat",   lat, 32'd3);
        check("add_busy",  busy1, 32'h1);
        check("add_out",   OUT, 32'h1300);
        check("add_flags", {CO, V, N, Z}, 32'h0);
        @(posedge clk); #1;
        check("done_pulse", {done, busy}, 32'h0);

        run_op(4'h0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 0, 1'b0);
        check("addv_out",   OUT, 32'h8000);
        check("addv_flags", {CO, V, N, Z}, 32'b0110);

        run_op(4'h1, 1'b0, 1'b1, 16'h8000, 16'h0001, 0, 1'b0);
        check("sub_out",   OUT, 32'h7FFF);
        check("sub_flags", {CO, V, N, Z}, 32'b1100);

        run_op(4'h9, 1'b0, 1'b1, 16'h0001, 16'h0000, 0, 1'b0);
        check("ror_out",   OUT, 32'h8000);
        check("ror_flags", {CO, V, N, Z}, 32'b1010);

        run_op(4'h8, 1'b0, 1'b1, 16'h0100, 16'h0000, 0, 1'b0);
        check("lsr_out",   OUT, 32'h0080);
        check("lsr_flags", {CO, V, N, Z}, 32'b0000);

        run_op(4'h6, 1'b0, 1'b1, 16'h8001, 16'h0000, 0, 1'b0);
        check("asl_out", OUT, 32'h0002);
        check("asl_co",  CO, 32'h1);

        run_op(4'h7, 1'b0, 1'b1, 16'h8001, 16'h0000, 0, 1'b0);
        check("rol_out", OUT, 32'h0003);
        check("rol_co",  CO, 32'h1);

        run_op(4'h0, 1'b1, 1'b0, 16'h9999, 16'h0001, 0, 1'b0);
        check("bcd1_out",   OUT, 32'h0000);
        check("bcd1_co_z",  {CO, Z}, 32'b11);

        run_op(4'h0, 1'b1, 1'b0, 16'h0999, 16'h0001, 0, 1'b0);
        check("bcd2_out",  OUT, 32'h1000);
        check("bcd2_co_z", {CO, Z}, 32'b00);

        run_op(4'h1, 1'b1, 1'b1, 16'h0010, 16'h0001, 0, 1'b0);
        check("sub_bcd_ignored", OUT, 32'h000F);

        run_op(4'hB, 1'b0, 1'b1, 16'h0000, 16'h1234, 0, 1'b0);
        check("dec_out",   OUT, 32'hFFFF);
        check("dec_flags", {CO, V, N, Z}, 32'b0010);

        run_op(4'hA, 1'b0, 1'b1, 16'hFFFF, 16'h1234, 0, 1'b0);
        check("inc_out",   OUT, 32'h0000);
        check("inc_flags", {CO, V, N, Z}, 32'b1001);

        run_op(4'h2, 1'b0, 1'b1, 16'hF0F0, 16'h0F00, 0, 1'b0);
        check("or_out",   OUT, 32'hFFF0);
        check("or_flags", {CO, V, N, Z}, 32'b1010);

        run_op(4'h3, 1'b0, 1'b0, 16'hF0F0, 16'h0FF0, 0, 1'b0);
        check("and_out", OUT, 32'h00F0);

        run_op(4'h4, 1'b0, 1'b0, 16'hA5A5, 16'hA5A5, 0, 1'b0);
        check("xor_out_z", {OUT, Z}, {15'd0, 16'h0000, 1'b1});

        run_op(4'h5, 1'b0, 1'b0, 16'h1234, 16'hFFFF, 0, 1'b0);
        check("pass_out", OUT, 32'h1234);

        run_op(4'hC, 1'b0, 1'b1, 16'h8000, 16'h00FF, 0, 1'b0);
        check("op_c_pass",   OUT, 32'h8000);
        check("op_c_flags",  {CO, V, N, Z}, 32'b1010);

        run_op(4'h0, 1'b0, 1'b0, 16'h0101, 16'h0101, 2, 1'b0);
        check("stall_lat", lat, 32'd5);
        check("stall_out", OUT, 32'h0202);

        run_op(4'h0, 1'b0, 1'b0, 16'h0001, 16'h0001, 0, 1'b1);
        check("junk_lat", lat, 32'd3);
        check("junk_out", OUT, 32'h0002);
        repeat (3) @(posedge clk);
        #1;
        check("hold_out",  OUT, 32'h0002);
        check("hold_idle", {busy, done}, 32'h0);

        @(posedge clk); #1;
        op = 4'h4; BCD = 1'b0; CI = 1'b1; AI = 16'h1111; BI = 16'h2222; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("mid_busy", busy, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_out",   OUT, 32'h0);
        check("mid_rst_flags", {CO, V, N, Z}, 32'b0001);
        check("mid_rst_busy",  {busy, done}, 32'h0);
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("mid_rst_quiet", seen, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
